// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction fetch queue between I-cache fetch and decode.
// Accepts up to two fetched instructions per cycle into a circular buffer and
// presents the two oldest entries to decode in program order. Validity of an
// entry derives only from the registered count, so storage is never reset.
// A pushed entry becomes visible on the outputs one cycle after it is written.
//
// Handshake: on the input side in_valid qualifies the fetch pair, and there is
// no ready; upstream must honour fetch_stall. A pair that does not fit is
// dropped whole and sets overflow_err. On the output side an entry transfers
// to decode in a cycle where its out_valid is high and it is accepted:
// dec_accept1 takes the head entry, and dec_accept2 takes head+1 only
// together with dec_accept1.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc1,
    input  logic [31:0] in_pc2,
    input  logic [31:0] in_inst1,
    input  logic [31:0] in_inst2,
    input  logic        in_exc,
    input  logic [6:0]  in_exc_cause,
    input  logic [1:0]  in_pred_taken,
    input  logic [31:0] in_pred_addr,
    output logic        fetch_stall,
    output logic        out_valid1,
    output logic        out_valid2,
    output logic [31:0] out_pc1,
    output logic [31:0] out_pc2,
    output logic [31:0] out_inst1,
    output logic [31:0] out_inst2,
    output logic        out_exc1,
    output logic        out_exc2,
    output logic [6:0]  out_exc_cause1,
    output logic [6:0]  out_exc_cause2,
    output logic        out_pred_taken1,
    output logic        out_pred_taken2,
    output logic [31:0] out_pred_addr1,
    output logic [31:0] out_pred_addr2,
    input  logic        dec_accept1,
    input  logic        dec_accept2,
    output logic        overflow_err
);

    localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
    // Leaves room for one in-flight I-cache pair plus the pair pushed now.
    localparam logic [PTR_W:0] STALL_TH = (PTR_W+1)'(DEPTH - 4);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_err_q, overflow_err_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] pc_mem_d    [DEPTH];
    logic [31:0] inst_mem_q  [DEPTH];
    logic [31:0] inst_mem_d  [DEPTH];
    logic        exc_mem_q   [DEPTH];
    logic        exc_mem_d   [DEPTH];
    logic [6:0]  cause_mem_q [DEPTH];
    logic [6:0]  cause_mem_d [DEPTH];
    logic        ptk_mem_q   [DEPTH];
    logic        ptk_mem_d   [DEPTH];
    logic [31:0] paddr_mem_q [DEPTH];
    logic [31:0] paddr_mem_d [DEPTH];

    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [PTR_W:0]   free_slots;
    logic             push_ok;
    logic             valid1;
    logic             valid2;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    assign valid1  = (count_q != '0);
    assign valid2  = (count_q >= (PTR_W+1)'(2));
    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Push/pop sizing, pointer/count update and storage writes.
    always_comb begin
        push_n         = 2'd0;
        pop_n          = 2'd0;
        free_slots     = DEPTH_C - count_q;
        push_ok        = 1'b0;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        overflow_err_d = overflow_err_q;
        pc_mem_d       = pc_mem_q;
        inst_mem_d     = inst_mem_q;
        exc_mem_d      = exc_mem_q;
        cause_mem_d    = cause_mem_q;
        ptk_mem_d      = ptk_mem_q;
        paddr_mem_d    = paddr_mem_q;

        // A taken slot1 means slot2 is on the wrong path and is not queued.
        if (in_valid && !flush) begin
            push_n = in_pred_taken[0] ? 2'd1 : 2'd2;
        end

        if (!flush && dec_accept1 && valid1) begin
            pop_n = (dec_accept2 && valid2) ? 2'd2 : 2'd1;
        end

        // Only the current count is considered; same-cycle pops do not free space.
        if (push_n != 2'd0) begin
            if (free_slots >= (PTR_W+1)'(push_n)) begin
                push_ok = 1'b1;
            end else begin
                overflow_err_d = 1'b1;
            end
        end

        if (push_ok) begin
            pc_mem_d[tail_q]    = in_pc1;
            inst_mem_d[tail_q]  = in_inst1;
            exc_mem_d[tail_q]   = in_exc;
            cause_mem_d[tail_q] = in_exc_cause;
            ptk_mem_d[tail_q]   = in_pred_taken[0];
            paddr_mem_d[tail_q] = in_pred_taken[0] ? in_pred_addr : 32'd0;
            if (push_n == 2'd2) begin
                pc_mem_d[tail_p1]    = in_pc2;
                inst_mem_d[tail_p1]  = in_inst2;
                exc_mem_d[tail_p1]   = in_exc;
                cause_mem_d[tail_p1] = in_exc_cause;
                ptk_mem_d[tail_p1]   = in_pred_taken[1];
                paddr_mem_d[tail_p1] = in_pred_taken[1] ? in_pred_addr : 32'd0;
            end
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = push_ok ? (tail_q + PTR_W'(push_n)) : tail_q;
            count_d = count_q + (push_ok ? (PTR_W+1)'(push_n) : '0) - (PTR_W+1)'(pop_n);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Entry storage; contents are meaningless until counted valid.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        inst_mem_q  <= inst_mem_d;
        exc_mem_q   <= exc_mem_d;
        cause_mem_q <= cause_mem_d;
        ptk_mem_q   <= ptk_mem_d;
        paddr_mem_q <= paddr_mem_d;
    end

    // Output read of head and head+1, zeroed when the slot is not valid.
    always_comb begin
        fetch_stall     = (count_q > STALL_TH);
        overflow_err    = overflow_err_q;
        out_valid1      = valid1;
        out_valid2      = valid2;
        out_pc1         = valid1 ? pc_mem_q[head_q]     : 32'd0;
        out_inst1       = valid1 ? inst_mem_q[head_q]   : 32'd0;
        out_exc1        = valid1 ? exc_mem_q[head_q]    : 1'b0;
        out_exc_cause1  = valid1 ? cause_mem_q[head_q]  : 7'd0;
        out_pred_taken1 = valid1 ? ptk_mem_q[head_q]    : 1'b0;
        out_pred_addr1  = valid1 ? paddr_mem_q[head_q]  : 32'd0;
        out_pc2         = valid2 ? pc_mem_q[head_p1]    : 32'd0;
        out_inst2       = valid2 ? inst_mem_q[head_p1]  : 32'd0;
        out_exc2        = valid2 ? exc_mem_q[head_p1]   : 1'b0;
        out_exc_cause2  = valid2 ? cause_mem_q[head_p1] : 7'd0;
        out_pred_taken2 = valid2 ? ptk_mem_q[head_p1]   : 1'b0;
        out_pred_addr2  = valid2 ? paddr_mem_q[head_p1] : 32'd0;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, pair push/pop, predicted-taken
// handling, fetch stall threshold, pointer wrap, overflow, flush and
// partial accept with exception propagation.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc1, in_pc2, in_inst1, in_inst2;
  logic        in_exc;
  logic [6:0]  in_exc_cause;
  logic [1:0]  in_pred_taken;
  logic [31:0] in_pred_addr;
  logic        fetch_stall;
  logic        out_valid1, out_valid2;
  logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
  logic        out_exc1, out_exc2;
  logic [6:0]  out_exc_cause1, out_exc_cause2;
  logic        out_pred_taken1, out_pred_taken2;
  logic [31:0] out_pred_addr1, out_pred_addr2;
  logic        dec_accept1, dec_accept2;
  logic        overflow_err;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  inst_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_pc1(in_pc1), .in_pc2(in_pc2), .in_inst1(in_inst1), .in_inst2(in_inst2),
    .in_exc(in_exc), .in_exc_cause(in_exc_cause),
    .in_pred_taken(in_pred_taken), .in_pred_addr(in_pred_addr),
    .fetch_stall(fetch_stall),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_pc2(out_pc2),
    .out_inst1(out_inst1), .out_inst2(out_inst2),
    .out_exc1(out_exc1), .out_exc2(out_exc2),
    .out_exc_cause1(out_exc_cause1), .out_exc_cause2(out_exc_cause2),
    .out_pred_taken1(out_pred_taken1), .out_pred_taken2(out_pred_taken2),
    .out_pred_addr1(out_pred_addr1), .out_pred_addr2(out_pred_addr2),
    .dec_accept1(dec_accept1), .dec_accept2(dec_accept2),
    .overflow_err(overflow_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0;
    in_pc1 = '0; in_pc2 = '0; in_inst1 = '0; in_inst2 = '0;
    in_exc = 1'b0; in_exc_cause = '0; in_pred_taken = '0; in_pred_addr = '0;
    dec_accept1 = 1'b0; dec_accept2 = 1'b0;
  endtask

  // advance one clock, then leave inputs idle
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_pair(input logic [31:0] pc1, input logic [31:0] pc2,
                            input logic [1:0] pred, input logic [31:0] paddr,
                            input logic exc, input logic [6:0] cause);
    in_valid = 1'b1;
    in_pc1 = pc1; in_pc2 = pc2;
    in_inst1 = pc1 ^ 32'h0280_0000; in_inst2 = pc2 ^ 32'h0280_0000;
    in_pred_taken = pred; in_pred_addr = paddr;
    in_exc = exc; in_exc_cause = cause;
  endtask

  task automatic push_pair(input logic [31:0] pc1, input logic [31:0] pc2);
    drive_pair(pc1, pc2, 2'b00, 32'd0, 1'b0, 7'd0);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic check_count(input string tag, input int exp);
    check_val(tag, 32'(dut.count_q), 32'(exp));
  endtask

  localparam logic [31:0] P = 32'h1c00_1000;

  initial begin
    int n_pop;
    logic [31:0] pc_next;
    logic acc1, acc2, do_push;
    checks = 0;
    failures = 0;
    idle();
    do_reset();

    // reset state
    check_val("rst_valid1", 32'(out_valid1), 0);
    check_val("rst_valid2", 32'(out_valid2), 0);
    check_val("rst_stall", 32'(fetch_stall), 0);
    check_val("rst_ovf", 32'(overflow_err), 0);
    check_val("rst_pc1", out_pc1, 0);
    check_count("rst_count", 0);

    // basic pair, no same-cycle bypass
    in_valid = 1'b1;
    in_pc1 = 32'h1c00_0000; in_pc2 = 32'h1c00_0004;
    in_inst1 = 32'h0280_0000; in_inst2 = 32'h0280_0400;
    #1;
    check_val("no_bypass", 32'(out_valid1), 0);
    cycle();
    check_val("basic_v1", 32'(out_valid1), 1);
    check_val("basic_v2", 32'(out_valid2), 1);
    check_val("basic_pc1", out_pc1, 32'h1c00_0000);
    check_val("basic_pc2", out_pc2, 32'h1c00_0004);
    check_val("basic_inst1", out_inst1, 32'h0280_0000);
    check_val("basic_inst2", out_inst2, 32'h0280_0400);
    check_count("basic_count", 2);
    dec_accept1 = 1'b1; dec_accept2 = 1'b1;
    cycle();
    check_val("basic_pop_v1", 32'(out_valid1), 0);
    check_val("basic_pop_v2", 32'(out_valid2), 0);

    // taken slot1 drops slot2
    drive_pair(32'h1c00_0010, 32'h1c00_0014, 2'b01, 32'h1c00_0100, 1'b0, 7'd0);
    cycle();
    check_count("tk1_count", 1);
    check_val("tk1_v2", 32'(out_valid2), 0);
    check_val("tk1_ptk1", 32'(out_pred_taken1), 1);
    check_val("tk1_paddr1", out_pred_addr1, 32'h1c00_0100);
    check_val("tk1_pc2_zero", out_pc2, 0);
    dec_accept1 = 1'b1;
    cycle();
    check_count("tk1_drain", 0);

    // taken slot2 keeps both
    drive_pair(32'h1c00_0020, 32'h1c00_0024, 2'b10, 32'h1c00_0100, 1'b0, 7'd0);
    cycle();
    check_count("tk2_count", 2);
    check_val("tk2_ptk1", 32'(out_pred_taken1), 0);
    check_val("tk2_paddr1", out_pred_addr1, 0);
    check_val("tk2_ptk2", 32'(out_pred_taken2), 1);
    check_val("tk2_paddr2", out_pred_addr2, 32'h1c00_0100);
    // accept2 without accept1 is a no-op
    dec_accept2 = 1'b1;
    cycle();
    check_count("acc2_only", 2);
    dec_accept1 = 1'b1; dec_accept2 = 1'b1;
    cycle();
    check_count("tk2_drain", 0);

    // stall threshold
    push_pair(P, P + 4);
    check_val("stall_c2", 32'(fetch_stall), 0);
    push_pair(P + 8, P + 12);
    check_val("stall_c4", 32'(fetch_stall), 0);
    push_pair(P + 16, P + 20);
    check_count("stall_count6", 6);
    check_val("stall_c6", 32'(fetch_stall), 1);
    dec_accept1 = 1'b1;
    cycle();
    check_val("stall_c5", 32'(fetch_stall), 1);
    check_val("stall_c5_pc1", out_pc1, P + 4);
    dec_accept1 = 1'b1;
    cycle();
    check_count("stall_count4", 4);
    check_val("stall_c4_fall", 32'(fetch_stall), 0);
    dec_accept1 = 1'b1;
    cycle();
    check_val("stall_c3_pc1", out_pc1, P + 12);

    // streaming push/pop across pointer wrap, scoreboard of PCs
    exp_q = {P + 12, P + 16, P + 20};
    pc_next = P + 24;
    for (int i = 0; i < 30; i++) begin
      check_val("wrap_v1", 32'(out_valid1), 32'(exp_q.size() >= 1));
      check_val("wrap_stall", 32'(fetch_stall), 32'(exp_q.size() > 4));
      if (exp_q.size() >= 1) check_val("wrap_pc1", out_pc1, exp_q[0]);
      if (exp_q.size() >= 2) check_val("wrap_pc2", out_pc2, exp_q[1]);
      acc1 = ((i % 3) != 2);
      acc2 = ((i % 2) == 0);
      n_pop = 0;
      if (acc1 && exp_q.size() >= 1) n_pop = 1;
      if (acc1 && acc2 && exp_q.size() >= 2) n_pop = 2;
      do_push = (exp_q.size() <= 4);
      dec_accept1 = acc1; dec_accept2 = acc2;
      if (do_push) drive_pair(pc_next, pc_next + 4, 2'b00, 32'd0, 1'b0, 7'd0);
      cycle();
      for (int k = 0; k < n_pop; k++) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(pc_next);
        exp_q.push_back(pc_next + 4);
        pc_next = pc_next + 8;
      end
      check_count("wrap_count", exp_q.size());
    end
    flush = 1'b1;
    cycle();
    check_count("wrap_flush", 0);

    // exactly full is not an overflow
    push_pair(P, P + 4);
    push_pair(P + 8, P + 12);
    push_pair(P + 16, P + 20);
    push_pair(P + 24, P + 28);
    check_count("full_count", 8);
    check_val("full_ovf", 32'(overflow_err), 0);
    flush = 1'b1;
    cycle();

    // overflow at count 7
    push_pair(P, P + 4);
    push_pair(P + 8, P + 12);
    push_pair(P + 16, P + 20);
    drive_pair(P + 24, P + 28, 2'b01, 32'h1c00_0200, 1'b0, 7'd0);
    cycle();
    check_count("ovf_count7", 7);
    check_val("ovf_before", 32'(overflow_err), 0);
    push_pair(P + 32, P + 36);
    check_count("ovf_drop", 7);
    check_val("ovf_set", 32'(overflow_err), 1);
    check_val("ovf_pc1", out_pc1, P);
    flush = 1'b1;
    cycle();
    check_count("ovf_flush_count", 0);
    check_val("ovf_sticky", 32'(overflow_err), 1);
    do_reset();
    check_val("ovf_rst", 32'(overflow_err), 0);

    // flush collides with push and pop
    push_pair(P, P + 4);
    push_pair(P + 8, P + 12);
    check_count("fcol_count4", 4);
    drive_pair(P + 16, P + 20, 2'b00, 32'd0, 1'b0, 7'd0);
    flush = 1'b1;
    dec_accept1 = 1'b1;
    cycle();
    check_count("fcol_count", 0);
    check_val("fcol_v1", 32'(out_valid1), 0);
    check_val("fcol_v2", 32'(out_valid2), 0);
    check_val("fcol_pc1", out_pc1, 0);
    check_val("fcol_inst2", out_inst2, 0);
    check_val("fcol_paddr1", out_pred_addr1, 0);

    // partial accept while pushing, exception propagation
    push_pair(P, P + 4);
    drive_pair(P + 8, P + 12, 2'b01, 32'h1c00_0300, 1'b0, 7'd0);
    cycle();
    check_count("part_count3", 3);
    drive_pair(P + 16, P + 20, 2'b00, 32'd0, 1'b1, 7'h08);
    dec_accept1 = 1'b1;
    cycle();
    check_count("part_count4", 4);
    check_val("part_pc1", out_pc1, P + 4);
    check_val("part_exc1_clear", 32'(out_exc1), 0);
    dec_accept1 = 1'b1; dec_accept2 = 1'b1;
    cycle();
    check_val("exc_pc1", out_pc1, P + 16);
    check_val("exc_flag1", 32'(out_exc1), 1);
    check_val("exc_cause1", 32'(out_exc_cause1), 32'h08);
    check_val("exc_flag2", 32'(out_exc2), 1);
    check_val("exc_cause2", 32'(out_exc_cause2), 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-issue instruction queue between the I-cache fetch stage and decode.
- Each cycle it accepts up to two fetched instructions, each with PC, exception tag and branch prediction.
- Each cycle it presents up to two oldest instructions to decode in program order.
- It decouples decode stalls from fetch by issuing a conservative fetch stall, and discards all contents on pipeline flush.

Parameters:
- DEPTH, 8: number of entries; power of two, ≥4.
- PTR_W, 3: log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush (branch mispredict / exception)
- in_valid  in  1  fetch pair valid (I-cache inst_valid)
- in_pc1, in_pc2  in  32  PCs of slot1/slot2
- in_inst1, in_inst2  in  32  instruction words
- in_exc  in  1  fetch exception, applies to both slots
- in_exc_cause  in  7  exception cause code
- in_pred_taken  in  2  bit0: slot1 predicted taken; bit1: slot2 predicted taken
- in_pred_addr  in  32  predicted target of the taken slot
- fetch_stall  out  1  upstream must not issue new fetch requests
- out_valid1, out_valid2  out  1  head / head+1 entry valid
- out_pc1, out_pc2  out  32  PCs
- out_inst1, out_inst2  out  32  instruction words
- out_exc1, out_exc2  out  1  exception flags
- out_exc_cause1, out_exc_cause2  out  7  exception causes
- out_pred_taken1, out_pred_taken2  out  1  predicted-taken flags
- out_pred_addr1, out_pred_addr2  out  32  predicted targets (0 if not taken)
- dec_accept1  in  1  decode consumes head entry
- dec_accept2  in  1  decode consumes head+1; only honoured with dec_accept1 and out_valid2
- overflow_err  out  1  sticky; a push was dropped for lack of space

Behaviour:
- State: circular buffer, head/tail pointers (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits, 0..DEPTH).
- Reset: head=tail=count=0, overflow_err=0.
- Reset effect on outputs: all out_valid*=0, fetch_stall=0, all out data fields=0.
- Push count push_n:
  - in_valid=0 or flush → 0.
  - in_pred_taken[0]=1 → 1 (slot2 is on the wrong path and is dropped).
  - Otherwise → 2.
- Pushed entry fields:
  - pc, inst from the slot; exc/cause = in_exc/in_exc_cause.
  - pred_taken = in_pred_taken bit of that slot.
  - pred_addr = in_pred_addr if that bit is set, else 0.
- Pop count pop_n = dec_accept1&out_valid1 + dec_accept1&dec_accept2&out_valid2. Ignored on flush.
- Accept on an invalid slot is a no-op.
- Write latency 1: an entry pushed in cycle N first appears on out_* in cycle N+1. No same-cycle bypass.
- Simultaneous push and pop are allowed: count <= count + push_n - pop_n.
  - Space check uses current count only (DEPTH - count ≥ push_n); pops in the same cycle do not free space.
- Insufficient space: the whole pair is dropped (no partial push) and overflow_err <= 1. This is a protocol violation.
- fetch_stall = (count > DEPTH-4), combinational on registered count.
  - The threshold reserves space for one in-flight I-cache pair plus the current push.
  - Compliant upstream therefore never overflows.
- Output read:
  - out_valid1 = count≥1; out_valid2 = count≥2.
  - Slot1 reads entry[head], slot2 reads entry[head+1 mod DEPTH].
  - Any field whose slot valid is 0 is driven 0.
- Flush: next cycle head=tail=count=0.
  - Same-cycle push and pop are discarded.
  - overflow_err is unchanged; only rst clears it.
- rst has priority over flush; flush has priority over push and pop.
- Storage needs no reset; validity derives solely from count.

Test Plan:
- Basic pair: rst, then push pc 0x1c000000/0x1c000004 with insts 0x02800000/0x02800400 → next cycle out_valid1=out_valid2=1 with those values, count=2; dec_accept1=dec_accept2=1 → both valids 0 the following cycle.
- Taken slot1: push with in_pred_taken=2'b01, in_pred_addr=0x1c000100 → only 1 entry, out_pred_taken1=1, out_pred_addr1=0x1c000100, out_valid2=0; with in_pred_taken=2'b10 → 2 entries, out_pred_addr1=0, out_pred_addr2=0x1c000100.
- Stall/wrap with DEPTH=8:
  - Push 3 pairs with no pops → count=6, fetch_stall=1.
  - Pop 1 per cycle for 3 cycles → fetch_stall falls when count=4.
  - Continue push/pop ≥20 cycles → PC order preserved across pointer wrap.
- Overflow: count=7, push pair → dropped, count stays 7, overflow_err=1; flush → count=0, overflow_err still 1; rst → 0.
- Flush collision: count=4, same cycle flush=1, in_valid=1, dec_accept1=1 → next cycle count=0, all out_valid=0, all out data 0.
- Partial accept: count=3, dec_accept1=1, dec_accept2=0 while pushing 2 → count=4, out_pc1 equals the former second entry's PC; exception entry (in_exc=1, cause 0x08) propagates to out_exc=1, out_exc_cause=0x08 on both slots.
